receptor_teclado: RTL
=====================

# receptor_teclado

Keyboard receiver: consumes the `teclas`/`valido` key stream produced by the keyboard model and turns each valid press into one queued event. Each event carries the key code and, optionally, the press duration. The block synchronizes and deglitches `valido`, latches the code, measures press length, and buffers events in a small show-ahead FIFO drained by a pop handshake. It sits between the keyboard interface and the consuming controller.

## Interface
- `MIN_PULSO`, default 3: synchronized-high cycles required to accept a press (≥1, ≤63).
- `PROFUNDIDAD`, default 4: FIFO depth in entries (power of 2, ≥2).
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset_L`  input  1  reset, asynchronous, active-low.
- `teclas`  input  5  key code; meaningful only while `valido`=1; X/Z otherwise.
- `valido`  input  1  key-present strobe, asynchronous to `clk`.
- `pop`  input  1  consumer removes head entry this cycle; ignored when `vacio`=1.
- `dato`  output  5  head-entry key code (show-ahead).
- `duracion`  output  6  head-entry press length in cycles, saturating at 63.
- `vacio`  output  1  FIFO empty.
- `lleno`  output  1  FIFO holds `PROFUNDIDAD` entries.
- `desborde`  output  1  sticky: an event was dropped because the FIFO was full.
- `presionada`  output  1  FSM is in PRESIONADA.

## Operation
- Reset values: `dato`=0, `duracion`=0, `vacio`=1, `lleno`=0, `desborde`=0, `presionada`=0. FSM=ESPERA, FIFO pointers and count=0, synchronizer flops=0.
- Synchronizer: `valido` → 2-flop chain → `valido_s`. `teclas` is sampled unsynchronized only when `valido_s`=1; the source holds it stable while `valido`=1.
- FSM:
  - ESPERA: `valido_s`=1 → FILTRO; latch `teclas`; `cuenta`=1.
  - FILTRO:
    - `valido_s`=0 → ESPERA; event discarded.
    - `teclas` ≠ latched code → relatch; `cuenta`=1.
    - Otherwise `cuenta`+1. When `cuenta` reaches `MIN_PULSO`, go to PRESIONADA. With `MIN_PULSO`=1, go ESPERA → FILTRO → PRESIONADA on consecutive high cycles.
  - PRESIONADA:
    - `valido_s`=1 → `cuenta`+1, saturating at 63; `teclas` changes are ignored.
    - `valido_s`=0 → push {code, `cuenta`}; → ESPERA.
- `cuenta` equals the number of `valido_s`-high cycles, including filter cycles.
- FIFO:
  - Push when not full, or when full with a pop in the same cycle: pop is applied first, then push; count unchanged.
  - Push when full without pop: entry dropped; `desborde`←1 until reset.
  - Pop when empty: no effect.
  - Pointers wrap modulo `PROFUNDIDAD`. `lleno`/`vacio` are derived from a registered count.
- Reset asserted mid-press or mid-FIFO: everything returns to reset values immediately and the FIFO is flushed. A press still held when reset releases is accepted as a new press.

## Timing
- `valido` rise → `valido_s` high after 2 clock edges.
- `valido_s` fall → push on the next edge → `vacio` low and `dato`/`duracion` valid on that edge. Total is 3 edges from the input fall.
- `pop` sampled at edge N → new head on `dato`/`duracion` after edge N; `vacio` updates at the same edge.
- A `valido` low gap shorter than one clock may be missed. The source guarantees a gap of ≥2 cycles.
- `presionada` rises on the edge where `cuenta` reaches `MIN_PULSO`.

## Configuration
- `RECEPTOR_DURACION_EN` defined: FIFO entries are 11 bits {code, duration}; `duracion` reports as specified.
- Not defined: FIFO entries are 5 bits and `duracion` is tied to 0. The `cuenta` saturating logic is still used for filtering, but its stored width is removed. All other behaviour is identical.

## Test plan
- Reset mid-press with 2 entries queued: `reset_L`=0 → `vacio`=1, `lleno`=0, `desborde`=0, `dato`=0, `duracion`=0, `presionada`=0; after release the FIFO is empty.
- `teclas`=5'b10110 with `valido` high for 10 cycles, `MIN_PULSO`=3 → one entry, `dato`=10110, `duracion`=10 (0 without macro); `vacio` falls 3 edges after the `valido` fall.
- `valido` high for 2 cycles, `MIN_PULSO`=3 → no entry; `vacio` stays 1; `presionada` never rises.
- 5 presses with codes 1..5 and no pop, `PROFUNDIDAD`=4 → `lleno`=1 after the 4th; 5th dropped; `desborde`=1; four pops return 1,2,3,4, then `vacio`=1.
- `valido` held high for 100 cycles → `duracion`=63.
- FIFO full, `pop`=1 in the same cycle as a push → count stays 4; `lleno`=1; `desborde`=0; the new code becomes the tail.

Source files
------------

// File: rtl/receptor_teclado.sv
// receptor_teclado: keyboard receiver.
//
// Synchronizes and deglitches the asynchronous `valido` strobe, latches the key code on
// `teclas`, measures how many synchronized cycles the key stays pressed and, on release,
// queues one event in a small show-ahead FIFO that the consumer drains with `pop`.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_L    in   asynchronous active-low reset
//   teclas     in   [4:0] key code, meaningful only while `valido` is high
//   valido     in   key-present strobe, asynchronous to `clk`
//   pop        in   remove head entry this cycle (ignored while empty)
//   dato       out  [4:0] head-entry key code (0 while empty)
//   duracion   out  [5:0] head-entry press length, saturating at 63 (0 while empty)
//   vacio      out  FIFO empty
//   lleno      out  FIFO holds PROFUNDIDAD entries
//   desborde   out  sticky: an event was dropped because the FIFO was full
//   presionada out  FSM is in the pressed state
//
// Configuration macro: RECEPTOR_DURACION_EN
//   defined   -> FIFO entries are {code, duration} (11 bits), `duracion` is live.
//   undefined -> FIFO entries hold only the code (5 bits), `duracion` is tied to 0.

module receptor_teclado #(
  parameter int unsigned MIN_PULSO   = 3,  // 1..63
  parameter int unsigned PROFUNDIDAD = 4   // power of 2, >= 2
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [4:0] teclas,
  input  logic       valido,
  input  logic       pop,
  output logic [4:0] dato,
  output logic [5:0] duracion,
  output logic       vacio,
  output logic       lleno,
  output logic       desborde,
  output logic       presionada
);

  localparam int unsigned PtrW = $clog2(PROFUNDIDAD);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [5:0] MinPulso = 6'(MIN_PULSO);
  localparam logic [5:0] CuentaMax = 6'd63;
  localparam logic [CntW-1:0] Prof = CntW'(PROFUNDIDAD);

`ifdef RECEPTOR_DURACION_EN
  localparam int unsigned EntryW = 11;
`else
  localparam int unsigned EntryW = 5;
`endif

  typedef enum logic [1:0] {
    StEspera,
    StFiltro,
    StPresionada
  } estado_e;

  // ---------------------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous strobe
  // ---------------------------------------------------------------------------------------
  logic valido_m_q, valido_s_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valido_m_q <= 1'b0;
      valido_s_q <= 1'b0;
    end else begin
      valido_m_q <= valido;
      valido_s_q <= valido_m_q;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Press FSM: filter short pulses, then measure the press and push on release
  // ---------------------------------------------------------------------------------------
  estado_e    estado_q, estado_d;
  logic [4:0] codigo_q, codigo_d;
  logic [5:0] cuenta_q, cuenta_d;
  logic       push;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      estado_q <= StEspera;
      codigo_q <= 5'd0;
      cuenta_q <= 6'd0;
    end else begin
      estado_q <= estado_d;
      codigo_q <= codigo_d;
      cuenta_q <= cuenta_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    codigo_d = codigo_q;
    cuenta_d = cuenta_q;
    push     = 1'b0;
    unique case (estado_q)
      StEspera: begin
        if (valido_s_q) begin
          estado_d = StFiltro;
          codigo_d = teclas;
          cuenta_d = 6'd1;
        end
      end
      StFiltro: begin
        if (!valido_s_q) begin
          estado_d = StEspera;
        end else if (teclas != codigo_q) begin
          // Code changed while still filtering: restart the qualification window.
          codigo_d = teclas;
          cuenta_d = 6'd1;
        end else begin
          // Cannot overflow: MIN_PULSO <= 63 ends the filter before the counter wraps.
          cuenta_d = cuenta_q + 6'd1;
          if (cuenta_d >= MinPulso) begin
            estado_d = StPresionada;
          end
        end
      end
      StPresionada: begin
        if (valido_s_q) begin
          if (cuenta_q != CuentaMax) begin
            cuenta_d = cuenta_q + 6'd1;
          end
        end else begin
          push     = 1'b1;
          estado_d = StEspera;
        end
      end
      default: estado_d = StEspera;
    endcase
  end

  assign presionada = (estado_q == StPresionada);

  // ---------------------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------------------
  logic [EntryW-1:0] mem_q [PROFUNDIDAD];
  logic [EntryW-1:0] entrada;
  logic [EntryW-1:0] cabeza;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              desborde_q, desborde_d;
  logic              pop_ok, push_ok, lleno_int;

`ifdef RECEPTOR_DURACION_EN
  assign entrada = {codigo_q, cuenta_q};
`else
  assign entrada = codigo_q;
`endif

  assign lleno_int = (cnt_q == Prof);

  always_comb begin
    pop_ok     = pop && (cnt_q != '0);
    // A pop in the same cycle frees the slot before the push lands.
    push_ok    = push && (!lleno_int || pop_ok);
    desborde_d = desborde_q | (push && lleno_int && !pop_ok);
    wr_ptr_d   = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop_ok);
    cnt_d      = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      desborde_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      desborde_q <= desborde_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= entrada;
    end
  end

  assign cabeza   = mem_q[rd_ptr_q];
  assign vacio    = (cnt_q == '0);
  assign lleno    = lleno_int;
  assign desborde = desborde_q;

`ifdef RECEPTOR_DURACION_EN
  assign dato     = vacio ? 5'd0 : cabeza[10:6];
  assign duracion = vacio ? 6'd0 : cabeza[5:0];
`else
  assign dato     = vacio ? 5'd0 : cabeza;
  assign duracion = 6'd0;
`endif

endmodule
